// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard-control bundle between the pipeline datapath and the stall/flush controller.
// master = datapath side (hazard sources, control sinks); slave = controller side.
interface pipeline_hazard_ctrl_if #(
    parameter int REG_ADDR_WIDTH = 5,
    parameter int CNT_WIDTH      = 32
);
    logic [REG_ADDR_WIDTH-1:0] Rs1_d;
    logic [REG_ADDR_WIDTH-1:0] Rs2_d;
    logic                      Rs1Used_d;
    logic                      Rs2Used_d;
    logic                      valid_e;
    logic [REG_ADDR_WIDTH-1:0] Rd_e;
    logic                      RegWrite_e;
    logic [1:0]                ResultSrc_e;
    logic                      PCSrc_e;
    logic                      valid_m;
    logic                      MemAccess_m;
    logic                      dcache_miss_m;
    logic                      mem_ready;

    logic                      refill_req;
    logic                      en_f;
    logic                      en_d;
    logic                      en_e;
    logic                      en_m;
    logic                      en_w;
    logic                      flush_n_d;
    logic                      flush_n_e;
    logic                      valid_mw;
    logic [CNT_WIDTH-1:0]      stall_cnt;

    modport master (
        output Rs1_d, Rs2_d, Rs1Used_d, Rs2Used_d,
        output valid_e, Rd_e, RegWrite_e, ResultSrc_e, PCSrc_e,
        output valid_m, MemAccess_m, dcache_miss_m, mem_ready,
        input  refill_req, en_f, en_d, en_e, en_m, en_w,
        input  flush_n_d, flush_n_e, valid_mw, stall_cnt
    );

    modport slave (
        input  Rs1_d, Rs2_d, Rs1Used_d, Rs2Used_d,
        input  valid_e, Rd_e, RegWrite_e, ResultSrc_e, PCSrc_e,
        input  valid_m, MemAccess_m, dcache_miss_m, mem_ready,
        output refill_req, en_f, en_d, en_e, en_m, en_w,
        output flush_n_d, flush_n_e, valid_mw, stall_cnt
    );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush controller: d-cache miss refill FSM, load-use and taken-branch handling, stall counter.
// Enables/flushes are combinational from the current cycle; refill_req and stall_cnt are registered.
module pipeline_hazard_ctrl #(
    parameter int REG_ADDR_WIDTH = 5,
    parameter int CNT_WIDTH      = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,
    pipeline_hazard_ctrl_if.slave   hz
);

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        MISS   = 2'b01,
        REPLAY = 2'b10
    } state_t;

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [REG_ADDR_WIDTH-1:0] REG_ZERO = '0;

    state_t                    state;
    logic                      refill_q;
    logic [CNT_WIDTH-1:0]      cnt_q;

    logic [REG_ADDR_WIDTH-1:0] rd_e;
    logic                      miss_det;
    logic                      miss_stall;
    logic                      branch;
    logic                      is_load_e;
    logic                      rs1_hit;
    logic                      rs2_hit;
    logic                      load_use;
    logic                      stall_evt;

    logic                      en_fd;
    logic                      en_em;
    logic                      fl_n_d;
    logic                      fl_n_e;
    logic                      vld_mw;

    assign rd_e      = hz.Rd_e;
    assign miss_det  = hz.valid_m & hz.MemAccess_m & hz.dcache_miss_m;
    assign miss_stall = ((state == IDLE) & miss_det) | (state == MISS) | (state == REPLAY);

    assign branch    = hz.valid_e & hz.PCSrc_e;
    assign is_load_e = hz.valid_e & hz.RegWrite_e & (hz.ResultSrc_e == 2'b01) & (rd_e != REG_ZERO);
    assign rs1_hit   = hz.Rs1Used_d & (hz.Rs1_d == rd_e);
    assign rs2_hit   = hz.Rs2Used_d & (hz.Rs2_d == rd_e);
    assign load_use  = is_load_e & (rs1_hit | rs2_hit);

    // Counted after priority: a load-use under a taken branch costs nothing.
    assign stall_evt = miss_stall | (load_use & ~branch);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            refill_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (miss_det) begin
                        state    <= MISS;
                        refill_q <= 1'b1;
                    end
                end
                MISS: begin
                    if (hz.mem_ready) begin
                        state    <= REPLAY;
                        refill_q <= 1'b0;
                    end
                end
                REPLAY: begin
                    state    <= IDLE;
                    refill_q <= 1'b0;
                end
                default: begin
                    state    <= IDLE;
                    refill_q <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (stall_evt && (cnt_q != CNT_MAX)) begin
            cnt_q <= cnt_q + CNT_ONE;
        end
    end

    // A miss freezes everything up to MEM and injects a WB bubble so the
    // held MEM instruction retires only once, after the replay.
    always_comb begin
        en_fd  = 1'b1;
        en_em  = 1'b1;
        fl_n_d = 1'b1;
        fl_n_e = 1'b1;
        vld_mw = hz.valid_m;
        if (!rst_n) begin
            vld_mw = 1'b0;
        end else if (miss_stall) begin
            en_fd  = 1'b0;
            en_em  = 1'b0;
            vld_mw = 1'b0;
        end else if (branch) begin
            fl_n_d = 1'b0;
            fl_n_e = 1'b0;
        end else if (load_use) begin
            en_fd  = 1'b0;
            fl_n_e = 1'b0;
        end
    end

    assign hz.en_f       = en_fd;
    assign hz.en_d       = en_fd;
    assign hz.en_e       = en_em;
    assign hz.en_m       = en_em;
    assign hz.en_w       = 1'b1;
    assign hz.flush_n_d  = fl_n_d;
    assign hz.flush_n_e  = fl_n_e;
    assign hz.valid_mw   = vld_mw;
    assign hz.refill_req = refill_q;
    assign hz.stall_cnt  = cnt_q;

endmodule

// File: doc/pipeline_hazard_ctrl.md
# pipeline_hazard_ctrl

Central stall/flush controller for the five-stage pipelined-plus-cache core. It drives the enable (`en`, active-high; low = stall) and flush (`rst_n`-style, active-low) inputs of the IF/ID, ID/EX, EX/MEM and MEM/WB stage registers and the PC. It sequences data-cache miss refills through a three-state FSM and detects load-use hazards and taken branches. It also keeps a saturating stall-cycle performance counter.

## Interface
Parameters:
- `REG_ADDR_WIDTH`, 5: register index width.
- `CNT_WIDTH`, 32: stall counter width.

Ports:
- `clk`  in  1  sole clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `Rs1_d`, `Rs2_d`  in  REG_ADDR_WIDTH  source registers of the instruction in decode.
- `Rs1Used_d`, `Rs2Used_d`  in  1  source actually read by the decode instruction.
- `valid_e`  in  1  execute-stage instruction valid.
- `Rd_e`  in  REG_ADDR_WIDTH  execute-stage destination register.
- `RegWrite_e`  in  1  execute-stage register write.
- `ResultSrc_e`  in  2  execute-stage result select; 2'b01 = load.
- `PCSrc_e`  in  1  taken branch/jump resolved in execute.
- `valid_m`  in  1  memory-stage instruction valid.
- `MemAccess_m`  in  1  memory-stage load or store.
- `dcache_miss_m`  in  1  data-cache miss for the current access.
- `mem_ready`  in  1  refill complete from the memory side.
- `refill_req`  out  1  refill request to memory, registered.
- `en_f`, `en_d`, `en_e`, `en_m`  out  1  enables for the PC, IF/ID, ID/EX and EX/MEM registers.
- `en_w`  out  1  MEM/WB enable; tied high.
- `flush_n_d`, `flush_n_e`  out  1  active-low flush for IF/ID and ID/EX.
- `valid_mw`  out  1  gated `valid_m`; drives the MEM/WB `valid_m` input.
- `stall_cnt`  out  CNT_WIDTH  stall cycles since reset.

## Operation
- FSM states are IDLE, MISS and REPLAY.
  - IDLE → MISS when `valid_m & MemAccess_m & dcache_miss_m`.
  - MISS → REPLAY when `mem_ready`; otherwise remain in MISS.
  - REPLAY → IDLE unconditionally after one cycle. `dcache_miss_m` is ignored in REPLAY.
- `refill_req` is 1 exactly while the state is MISS.
- `miss_stall` = (IDLE & miss detect) | MISS | REPLAY. It is combinational in the detect cycle.
- `load_use` = `valid_e & RegWrite_e & ResultSrc_e==2'b01 & Rd_e!=0 & ((Rs1Used_d & Rs1_d==Rd_e) | (Rs2Used_d & Rs2_d==Rd_e))`.
- `branch` = `valid_e & PCSrc_e`.
- Priority is `miss_stall` > `branch` > `load_use`. Outputs per case:
  - **miss_stall:** `en_f`=`en_d`=`en_e`=`en_m`=0; flushes inactive; `valid_mw`=0, so a bubble enters WB and the held MEM instruction does not retire twice.
  - **branch (no miss):** `flush_n_d`=0 and `flush_n_e`=0; all enables 1. The load-use check is suppressed because the decode instruction is killed.
  - **load_use only:** `en_f`=`en_d`=0 and `flush_n_e`=0, inserting one bubble in EX; `en_e`=`en_m`=1.
  - **None of these:** all enables 1, flushes 1, `valid_mw`=`valid_m`.
- `stall_cnt` increments by 1 in every cycle with `miss_stall | load_use`, counted after priority. A load-use masked by a branch is not counted. The counter saturates at all-ones.
- A branch or load-use that arrives during a miss is held, because EX is frozen. It takes effect in the first non-stall cycle.

## Timing
- Reset (async, `rst_n`=0) sets state to IDLE, `refill_req`=0 and `stall_cnt`=0.
- While `rst_n`=0, the combinational outputs are forced to: all `en_*`=1, `flush_n_*`=1, `valid_mw`=0.
- Reset asserted mid-miss drops `refill_req` immediately. After release the controller returns to IDLE with no replay.
- Load-use costs exactly 1 stall cycle.
- A taken branch costs 2 flushed slots, both in the same cycle.
- A miss detected in cycle T has these timings:
  - `refill_req`=1 from T+1.
  - If `mem_ready` is sampled high at cycle T+k, REPLAY occurs at T+k+1 and IDLE at T+k+2.
  - The pipeline resumes advancing at T+k+2. Stall length is k+2 cycles.
- `mem_ready` while not in MISS is ignored.
- A miss asserted again in the first IDLE cycle after REPLAY starts a new refill. No lockout is applied.

## Test plan
- **Load-use:** `Rd_e`=5, load in EX, `Rs1_d`=5, `Rs1Used_d`=1 → one cycle with `en_f`=`en_d`=0 and `flush_n_e`=0; `stall_cnt` 0→1.
- **x0 and unused source:** `Rd_e`=0, or `Rs2_d`=`Rd_e` with `Rs2Used_d`=0 → no stall, `stall_cnt` unchanged.
- **Branch vs load-use:** `PCSrc_e`=1 concurrent with a load-use match → `flush_n_d`=`flush_n_e`=0, `en_f`=1, `stall_cnt` unchanged.
- **Miss refill:** miss at cycle 10, `mem_ready` at cycle 14 → `refill_req` high in cycles 11-14, REPLAY at 15, IDLE at 16; `en_m`=0 and `valid_mw`=0 for cycles 10-15; `stall_cnt`=6.
- **Branch during miss:** `PCSrc_e`=1 held through the miss → no flush until the first cycle after REPLAY, then exactly one flush cycle.
- **Reset mid-MISS:** `rst_n` low in MISS → `refill_req`=0 the same cycle and `stall_cnt`=0. Separately, preload the counter to all-ones minus 1 and apply 3 stalls → counter holds at all-ones.
